carrier_loop_sequencer: RTL and testbench
=========================================

Name: carrier_loop_sequencer

Overview:
- Acquisition/tracking controller for the carrier-loop lag-gain accumulator.
- Drives that accumulator's lagExp, sweepEnable, carrierInSync and clearAccum inputs from a lock-detector flag.
- Sequences clear → sweep → lock verify → gradual gear-shift of lag gain → track, with a loss-of-lock hold before re-sweeping.
- Sits between the loop lock detector / register bank and the lag-gain block; all timing is in loop-update (clkEn) ticks.

Parameters:
CNT_W, 16, width of the verify/gear/hold tick counters and their config inputs.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
clkEn  in  1  loop update strobe; same strobe drives the lag-gain accumulator
enable  in  1  loop sequencing enable (register bit)
restart  in  1  single-clk pulse; forces re-acquisition
lockDetect  in  1  carrier lock flag from lock detector, sampled on clkEn
acqLagExp  in  5  lag exponent used while sweeping/verifying
trkLagExp  in  5  final tracking lag exponent
verifyCnt  in  CNT_W  consecutive locked ticks required to declare sync
gearCnt  in  CNT_W  ticks spent at each lag-exponent step while gearing
holdCnt  in  CNT_W  consecutive unlocked ticks tolerated before re-sweep
lagExp  out  5  to lag-gain block
sweepEnable  out  1  to lag-gain block
carrierInSync  out  1  to lag-gain block and status
clearAccum  out  1  to lag-gain block; one-clk pulse
acqState  out  3  current state, for status register

Behaviour:
- Reset (async): state=OFF, lagExp=5'h00, sweepEnable=0, carrierInSync=0, clearAccum=0, counter=0, acqState=0.
- All outputs are registered. Counter compares treat a zero count config as 1.
- Priority, evaluated every clk (not clkEn-gated): (1) enable=0 → OFF; (2) restart=1 → CLEAR; (3) state logic.
- State logic: CLEAR is evaluated every clk. All other transitions and counting occur only on clkEn=1.
- OFF: lagExp=acqLagExp, sweepEnable=0, carrierInSync=0. On enable=1 → CLEAR next clk.
- CLEAR: clearAccum=1 for exactly one clk; lagExp=acqLagExp. → SWEEP on the next clk regardless of clkEn.
- SWEEP: sweepEnable=1, carrierInSync=0, lagExp=acqLagExp (tracks register live).
  - lockDetect=1 → VERIFY, counter=1.
- VERIFY: sweepEnable=1, carrierInSync=1 (freezes sweep offset at 0 while verifying), lagExp=acqLagExp.
  - lockDetect=0 → SWEEP (counter cleared, no clear pulse).
  - lockDetect=1 and counter ≥ verifyCnt → GEAR, counter=0.
  - Otherwise counter+1.
- GEAR: carrierInSync=1, sweepEnable=1. lagExp steps by 1 toward trkLagExp (down or up) each time counter reaches gearCnt; counter then resets to 0.
  - lagExp==trkLagExp → TRACK. If acqLagExp==trkLagExp, GEAR lasts a single clkEn tick.
  - lockDetect=0 → HOLD (counter=1, gear position retained).
- TRACK: lagExp=trkLagExp (tracks register live), carrierInSync=1, sweepEnable=1.
  - lockDetect=0 → HOLD, counter=1.
- HOLD: outputs unchanged from the entering state.
  - lockDetect=1 → return to GEAR if lagExp≠trkLagExp, else TRACK; counter=0.
  - counter ≥ holdCnt → CLEAR.
  - Otherwise counter+1.
- Counters saturate at all-ones; they never wrap.
- restart during CLEAR re-enters CLEAR and yields one additional clearAccum pulse.
- enable drop mid-operation → OFF next clk; any clearAccum pulse in flight is dropped.

Decomposition:
- Shared package:
  - state encodings OFF=0, CLEAR=1, SWEEP=2, VERIFY=3, GEAR=4, TRACK=5, HOLD=6 (also used by the status register decode);
  - LAG_EXP_W=5.
- One natural sub-module, sat_tick_counter: CNT_W-bit counter with clkEn, clear, load-1, saturate, and ≥-compare output. It is instantiated once and shared by VERIFY/GEAR/HOLD.

Test Plan:
- Reset asserted mid-GEAR → all outputs 0, acqState=0 immediately (async); after release with enable=1 → one clearAccum pulse, then SWEEP.
- acqLagExp=12, verifyCnt=4, lockDetect high from tick 10 → VERIFY at tick 10; GEAR after the 4th consecutive locked tick; carrierInSync=1 from VERIFY entry.
- Lock drops on 3rd VERIFY tick → SWEEP next tick, sweepEnable=1, carrierInSync=0, no clearAccum.
- acqLagExp=12, trkLagExp=8, gearCnt=3 → lagExp 12,11,10,9,8 at 3-tick spacing, then TRACK; acqLagExp=5, trkLagExp=8 → steps up 5..8.
- In TRACK, holdCnt=5: unlock for 4 ticks then relock → back to TRACK, lagExp=8. Unlock for 5 ticks → CLEAR pulse, then SWEEP with lagExp=12.
- restart pulse in TRACK between clkEn strobes → CLEAR on the next clk without waiting for clkEn; enable=0 in SWEEP → OFF, sweepEnable=0 next clk.

Source files
------------

// File: rtl/carrier_loop_sequencer_pkg.sv
// Carrier loop sequencer shared types.
// State encodings double as the status register decode.
package carrier_loop_sequencer_pkg;

  localparam int LAG_EXP_W = 5;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_SWEEP  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_GEAR   = 3'd4,
    ST_TRACK  = 3'd5,
    ST_HOLD   = 3'd6
  } acq_state_e;

  function automatic logic [LAG_EXP_W-1:0] step_toward(
    input logic [LAG_EXP_W-1:0] cur,
    input logic [LAG_EXP_W-1:0] tgt
  );
    logic [LAG_EXP_W-1:0] r;
    r = cur;
    if (cur > tgt) r = cur - 1'b1;
    else if (cur < tgt) r = cur + 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/carrier_loop_sequencer_sat_tick_counter.sv
// Saturating tick counter shared by the verify, gear and hold phases.
// hit_o compares the count including the current tick against the limit.
module sat_tick_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             clr_i,
  input  logic             ld1_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             hit_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] lim;

  always_comb begin
    cnt_nxt = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    lim = (limit_i == '0) ? CNT_W'(1) : limit_i;
    hit_o = (cnt_nxt >= lim);
    cnt_d = cnt_q;
    if (clr_i) cnt_d = '0;
    else if (tick_i && ld1_i) cnt_d = CNT_W'(1);
    else if (tick_i && inc_i) cnt_d = cnt_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

endmodule

// File: rtl/carrier_loop_sequencer.sv
// Acquisition/tracking sequencer for the carrier-loop lag-gain block:
// clear, sweep, verify lock, gear lag exponent down/up, track, hold.
module carrier_loop_sequencer
  import carrier_loop_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clkEn,
  input  logic                 enable,
  input  logic                 restart,
  input  logic                 lockDetect,
  input  logic [LAG_EXP_W-1:0] acqLagExp,
  input  logic [LAG_EXP_W-1:0] trkLagExp,
  input  logic [CNT_W-1:0]     verifyCnt,
  input  logic [CNT_W-1:0]     gearCnt,
  input  logic [CNT_W-1:0]     holdCnt,
  output logic [LAG_EXP_W-1:0] lagExp,
  output logic                 sweepEnable,
  output logic                 carrierInSync,
  output logic                 clearAccum,
  output logic [2:0]           acqState
);

  acq_state_e           state_q, state_d;
  logic [LAG_EXP_W-1:0] lag_q, lag_d;
  logic [LAG_EXP_W-1:0] gear_lag;
  logic                 sweep_q, sweep_d;
  logic                 sync_q, sync_d;
  logic                 clr_q, clr_d;
  logic                 at_trk;
  logic                 cnt_clr, cnt_ld1, cnt_inc;
  logic                 cnt_hit;
  logic [CNT_W-1:0]     cnt_lim;

  always_comb begin
    unique case (state_q)
      ST_GEAR: cnt_lim = gearCnt;
      ST_HOLD: cnt_lim = holdCnt;
      default: cnt_lim = verifyCnt;
    endcase
  end

  sat_tick_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (reset),
    .tick_i (clkEn),
    .clr_i  (cnt_clr),
    .ld1_i  (cnt_ld1),
    .inc_i  (cnt_inc),
    .limit_i(cnt_lim),
    .hit_o  (cnt_hit)
  );

  always_comb begin
    state_d  = state_q;
    gear_lag = lag_q;
    cnt_clr  = 1'b0;
    cnt_ld1  = 1'b0;
    cnt_inc  = 1'b0;
    at_trk   = (lag_q == trkLagExp);
    if (!enable) begin
      state_d = ST_OFF;
      cnt_clr = 1'b1;
    end else if (restart) begin
      state_d = ST_CLEAR;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_OFF: state_d = ST_CLEAR;
        ST_CLEAR: begin
          state_d = ST_SWEEP;
          cnt_clr = 1'b1;
        end
        ST_SWEEP: begin
          if (clkEn && lockDetect) begin
            state_d = ST_VERIFY;
            cnt_ld1 = 1'b1;
          end
        end
        ST_VERIFY: begin
          if (clkEn) begin
            if (!lockDetect) begin
              state_d = ST_SWEEP;
              cnt_clr = 1'b1;
            end else if (cnt_hit) begin
              state_d = ST_GEAR;
              cnt_clr = 1'b1;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        ST_GEAR: begin
          if (clkEn) begin
            if (!lockDetect) begin
              state_d = ST_HOLD;
              cnt_ld1 = 1'b1;
            end else if (at_trk) begin
              state_d = ST_TRACK;
              cnt_clr = 1'b1;
            end else if (cnt_hit) begin
              gear_lag = step_toward(lag_q, trkLagExp);
              cnt_clr  = 1'b1;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        ST_TRACK: begin
          if (clkEn && !lockDetect) begin
            state_d = ST_HOLD;
            cnt_ld1 = 1'b1;
          end
        end
        ST_HOLD: begin
          if (clkEn) begin
            if (lockDetect) begin
              state_d = at_trk ? ST_TRACK : ST_GEAR;
              cnt_clr = 1'b1;
            end else if (cnt_hit) begin
              state_d = ST_CLEAR;
              cnt_clr = 1'b1;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // Outputs are registered from the next state; HOLD freezes them.
  always_comb begin
    lag_d   = lag_q;
    sweep_d = sweep_q;
    sync_d  = sync_q;
    clr_d   = 1'b0;
    unique case (state_d)
      ST_OFF: begin
        lag_d   = acqLagExp;
        sweep_d = 1'b0;
        sync_d  = 1'b0;
      end
      ST_CLEAR: begin
        lag_d   = acqLagExp;
        sweep_d = 1'b0;
        sync_d  = 1'b0;
        clr_d   = 1'b1;
      end
      ST_SWEEP: begin
        lag_d   = acqLagExp;
        sweep_d = 1'b1;
        sync_d  = 1'b0;
      end
      ST_VERIFY: begin
        lag_d   = acqLagExp;
        sweep_d = 1'b1;
        sync_d  = 1'b1;
      end
      ST_GEAR: begin
        lag_d   = gear_lag;
        sweep_d = 1'b1;
        sync_d  = 1'b1;
      end
      ST_TRACK: begin
        lag_d   = trkLagExp;
        sweep_d = 1'b1;
        sync_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_OFF;
      lag_q   <= '0;
      sweep_q <= 1'b0;
      sync_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lag_q   <= lag_d;
      sweep_q <= sweep_d;
      sync_q  <= sync_d;
      clr_q   <= clr_d;
    end
  end

  assign lagExp        = lag_q;
  assign sweepEnable   = sweep_q;
  assign carrierInSync = sync_q;
  assign clearAccum    = clr_q;
  assign acqState      = state_q;

endmodule

// File: tb/tb_carrier_loop_sequencer.sv
// Directed bench for carrier_loop_sequencer: vector table plus
// hand sequences for gearing, hold, restart, enable drop and async reset.
module tb_carrier_loop_sequencer;

  localparam int CNT_W = 16;
  localparam logic [2:0] S_OFF = 3'd0;
  localparam logic [2:0] S_CLR = 3'd1;
  localparam logic [2:0] S_SWP = 3'd2;
  localparam logic [2:0] S_VER = 3'd3;
  localparam logic [2:0] S_GR  = 3'd4;
  localparam logic [2:0] S_TRK = 3'd5;
  localparam logic [2:0] S_HLD = 3'd6;

  logic clk = 1'b0;
  logic reset, clkEn, enable, restart, lockDetect;
  logic [4:0] acqLagExp, trkLagExp;
  logic [CNT_W-1:0] verifyCnt, gearCnt, holdCnt;
  logic [4:0] lagExp;
  logic sweepEnable, carrierInSync, clearAccum;
  logic [2:0] acqState;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  carrier_loop_sequencer #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .clkEn        (clkEn),
    .enable       (enable),
    .restart      (restart),
    .lockDetect   (lockDetect),
    .acqLagExp    (acqLagExp),
    .trkLagExp    (trkLagExp),
    .verifyCnt    (verifyCnt),
    .gearCnt      (gearCnt),
    .holdCnt      (holdCnt),
    .lagExp       (lagExp),
    .sweepEnable  (sweepEnable),
    .carrierInSync(carrierInSync),
    .clearAccum   (clearAccum),
    .acqState     (acqState)
  );

  typedef struct {
    logic       en;
    logic       rs;
    logic       ce;
    logic       lk;
    logic [2:0] st;
    logic [4:0] lag;
    logic       sw;
    logic       sy;
    logic       cl;
    string      nm;
  } vec_t;

  vec_t tbl[16];

  task automatic cyc(input logic en, input logic rs,
                     input logic ce, input logic lk);
    enable = en;
    restart = rs;
    clkEn = ce;
    lockDetect = lk;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [2:0] st,
                     input logic [4:0] lag, input logic sw,
                     input logic sy, input logic cl);
    checks++;
    if ({acqState, lagExp, sweepEnable, carrierInSync, clearAccum}
        !== {st, lag, sw, sy, cl}) begin
      errors++;
      $display("FAIL %s: got st=%0d lag=%0d sw=%b sy=%b cl=%b want st=%0d lag=%0d sw=%b sy=%b cl=%b",
               nm, acqState, lagExp, sweepEnable, carrierInSync, clearAccum,
               st, lag, sw, sy, cl);
    end
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, S_OFF, 5'd12, 1'b0, 1'b0, 1'b0, "off"};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, S_CLR, 5'd12, 1'b0, 1'b0, 1'b1, "clear"};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, S_SWP, 5'd12, 1'b1, 1'b0, 1'b0, "sweep"};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, S_SWP, 5'd12, 1'b1, 1'b0, 1'b0, "sweep_nolock"};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, S_SWP, 5'd12, 1'b1, 1'b0, 1'b0, "sweep_notick"};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, S_VER, 5'd12, 1'b1, 1'b1, 1'b0, "verify_in"};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, S_VER, 5'd12, 1'b1, 1'b1, 1'b0, "verify_2"};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, S_SWP, 5'd12, 1'b1, 1'b0, 1'b0, "verify_drop"};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, S_VER, 5'd12, 1'b1, 1'b1, 1'b0, "reverify"};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, S_VER, 5'd12, 1'b1, 1'b1, 1'b0, "verify_2b"};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, S_VER, 5'd12, 1'b1, 1'b1, 1'b0, "verify_notick"};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, S_VER, 5'd12, 1'b1, 1'b1, 1'b0, "verify_3"};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1, S_GR,  5'd12, 1'b1, 1'b1, 1'b0, "gear_in"};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b1, S_GR,  5'd12, 1'b1, 1'b1, 1'b0, "gear_c1"};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b1, S_GR,  5'd12, 1'b1, 1'b1, 1'b0, "gear_c2"};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 1'b1, S_GR,  5'd11, 1'b1, 1'b1, 1'b0, "gear_11"};

    reset = 1'b1;
    enable = 1'b0;
    restart = 1'b0;
    clkEn = 1'b0;
    lockDetect = 1'b0;
    acqLagExp = 5'd12;
    trkLagExp = 5'd8;
    verifyCnt = 16'd4;
    gearCnt = 16'd3;
    holdCnt = 16'd5;

    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset", S_OFF, 5'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].en, tbl[i].rs, tbl[i].ce, tbl[i].lk);
      chk(tbl[i].nm, tbl[i].st, tbl[i].lag, tbl[i].sw, tbl[i].sy, tbl[i].cl);
    end

    // Gear down 11 -> 8 at three-tick spacing, then TRACK.
    for (int l = 10; l >= 8; l--) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b1);
      chk("gear_wait1", S_GR, 5'(l + 1), 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b1);
      chk("gear_wait2", S_GR, 5'(l + 1), 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b1);
      chk("gear_step", S_GR, 5'(l), 1'b1, 1'b1, 1'b0);
    end
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    chk("track_in", S_TRK, 5'd8, 1'b1, 1'b1, 1'b0);

    // Four unlocked ticks then relock: back to TRACK.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      chk("hold_short", S_HLD, 5'd8, 1'b1, 1'b1, 1'b0);
    end
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    chk("hold_relock", S_TRK, 5'd8, 1'b1, 1'b1, 1'b0);

    // Five unlocked ticks: fall back to CLEAR then SWEEP.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      chk("hold_long", S_HLD, 5'd8, 1'b1, 1'b1, 1'b0);
    end
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("hold_expire", S_CLR, 5'd12, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("resweep", S_SWP, 5'd12, 1'b1, 1'b0, 1'b0);

    // Gear up 5 -> 8 with gearCnt=0 acting as 1.
    acqLagExp = 5'd5;
    gearCnt = 16'd0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("sweep_live", S_SWP, 5'd5, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b1);
      chk("up_verify", S_VER, 5'd5, 1'b1, 1'b1, 1'b0);
    end
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    chk("up_gear_in", S_GR, 5'd5, 1'b1, 1'b1, 1'b0);
    for (int l = 6; l <= 8; l++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b1);
      chk("up_step", S_GR, 5'(l), 1'b1, 1'b1, 1'b0);
    end
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    chk("up_track", S_TRK, 5'd8, 1'b1, 1'b1, 1'b0);

    // Restart without clkEn, then restart again while in CLEAR.
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("restart", S_CLR, 5'd5, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("restart_clr", S_CLR, 5'd5, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("restart_swp", S_SWP, 5'd5, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("en_drop", S_OFF, 5'd5, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("clr_again", S_CLR, 5'd5, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("drop_clr", S_OFF, 5'd5, 1'b0, 1'b0, 1'b0);

    // Async reset asserted mid-GEAR.
    acqLagExp = 5'd12;
    verifyCnt = 16'd1;
    gearCnt = 16'd3;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("pre_swp", S_SWP, 5'd12, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    chk("pre_gear", S_GR, 5'd12, 1'b1, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst", S_OFF, 5'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_held", S_OFF, 5'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_rst_clr", S_CLR, 5'd12, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_rst_swp", S_SWP, 5'd12, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
